// File: rtl/ysyx_22041071_mem_stage.sv
// Memory-access pipeline stage: takes one instruction from execute, issues loads/stores
// to data memory, and hands PC/instruction/write-back data to the write-back stage.
module ysyx_22041071_mem_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INS_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid5,
    output logic              ready5,
    input  logic [ADDR_W-1:0] PC5,
    input  logic [INS_W-1:0]  Ins4,
    input  logic              reg_w_en3,
    input  logic [4:0]        rdest3_in,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        mem_op,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              valid6,
    input  logic              ready6,
    output logic [ADDR_W-1:0] PC6,
    output logic [INS_W-1:0]  Ins5,
    output logic              reg_w_en4,
    output logic [4:0]        rdest3,
    output logic [DATA_W-1:0] WB_data1
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INS_W-1:0]    ins_q, ins_d;
    logic                wen_q, wen_d;
    logic [4:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   wb_q, wb_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                req_wen_q, req_wen_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [7:0]          req_wmask_q, req_wmask_d;

    logic                accept;
    logic [2:0]          off_in;
    logic [7:0]          st_base;
    logic [7:0]          st_mask;
    logic [DATA_W-1:0]   st_data;
    logic [DATA_W-1:0]   ld_raw;
    logic [DATA_W-1:0]   ld_ext;

    // Store lane placement; bytes shifted past the 8-byte word are simply lost.
    always_comb begin
        off_in = alu_res[2:0];
        st_base = 8'hFF;
        unique case (mem_op[1:0])
            2'b00: st_base = 8'h01;
            2'b01: st_base = 8'h03;
            2'b10: st_base = 8'h0F;
            2'b11: st_base = 8'hFF;
        endcase
        st_mask = st_base << off_in;
        st_data = store_data << {off_in, 3'b000};
    end

    // Load extraction; wb_q still holds the captured address while waiting.
    always_comb begin
        ld_raw = mem_resp_rdata >> {wb_q[2:0], 3'b000};
        unique case (op_q)
            3'b000:  ld_ext = {{(DATA_W-8){ld_raw[7]}}, ld_raw[7:0]};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_raw[7:0]};
            3'b001:  ld_ext = {{(DATA_W-16){ld_raw[15]}}, ld_raw[15:0]};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_raw[15:0]};
            3'b010:  ld_ext = {{(DATA_W-32){ld_raw[31]}}, ld_raw[31:0]};
            3'b110:  ld_ext = {{(DATA_W-32){1'b0}}, ld_raw[31:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    always_comb begin
        ready5        = (state_q == StIdle) || ((state_q == StOut) && ready6);
        valid6        = (state_q == StOut);
        mem_req_valid = (state_q == StReq);
        accept        = valid5 && ready5;

        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        wen_d       = wen_q;
        rd_d        = rd_q;
        wb_d        = wb_q;
        op_d        = op_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;

        unique case (state_q)
            StIdle: ;
            StReq: begin
                if (mem_req_ready) state_d = req_wen_q ? StOut : StWait;
            end
            StWait: begin
                if (mem_resp_valid) begin
                    wb_d    = ld_ext;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (ready6) state_d = StIdle;
            end
        endcase

        if (accept) begin
            pc_d  = PC5;
            ins_d = Ins4;
            wen_d = reg_w_en3;
            rd_d  = rdest3_in;
            wb_d  = alu_res;
            op_d  = mem_op;
            if (mem_rd || mem_wr) begin
                state_d     = StReq;
                req_addr_d  = {alu_res[ADDR_W-1:3], 3'b000};
                req_wen_d   = !mem_rd;
                req_wdata_d = mem_rd ? '0 : st_data;
                req_wmask_d = mem_rd ? 8'h00 : st_mask;
            end else begin
                state_d = StOut;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            ins_q       <= '0;
            wen_q       <= 1'b0;
            rd_q        <= '0;
            wb_q        <= '0;
            op_q        <= '0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            wen_q       <= wen_d;
            rd_q        <= rd_d;
            wb_q        <= wb_d;
            op_q        <= op_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
        end
    end

    assign PC6           = pc_q;
    assign Ins5          = ins_q;
    assign reg_w_en4     = wen_q;
    assign rdest3        = rd_q;
    assign WB_data1      = wb_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_ysyx_22041071_mem_stage.sv
// Directed bench for the memory stage: a scoreboard queue holds expected write-back
// results, popped whenever the stage hands an instruction to write-back.
module tb_ysyx_22041071_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid5, ready5;
    logic [63:0] PC5;
    logic [31:0] Ins4;
    logic        reg_w_en3;
    logic [4:0]  rdest3_in;
    logic [63:0] alu_res, store_data;
    logic        mem_rd, mem_wr;
    logic [2:0]  mem_op;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        valid6, ready6;
    logic [63:0] PC6;
    logic [31:0] Ins5;
    logic        reg_w_en4;
    logic [4:0]  rdest3;
    logic [63:0] WB_data1;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wb;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_push = 0;
    int          n_pop = 0;
    logic [63:0] pc_n = 64'h8000_0000;

    ysyx_22041071_mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid5         (valid5),
        .ready5         (ready5),
        .PC5            (PC5),
        .Ins4           (Ins4),
        .reg_w_en3      (reg_w_en3),
        .rdest3_in      (rdest3_in),
        .alu_res        (alu_res),
        .store_data     (store_data),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_op         (mem_op),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .valid6         (valid6),
        .ready6         (ready6),
        .PC6            (PC6),
        .Ins5           (Ins5),
        .reg_w_en4      (reg_w_en4),
        .rdest3         (rdest3),
        .WB_data1       (WB_data1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction into the stage and record its expected write-back result.
    task automatic issue(input logic rd_i, input logic wr_i, input logic [2:0] op,
                         input logic [63:0] alu, input logic [63:0] sdata, input logic wen,
                         input logic [4:0] rd, input logic [63:0] exp_wb);
        exp_t e;
        valid5 = 1'b1;
        mem_rd = rd_i;
        mem_wr = wr_i;
        mem_op = op;
        alu_res = alu;
        store_data = sdata;
        reg_w_en3 = wen;
        rdest3_in = rd;
        PC5 = pc_n;
        Ins4 = pc_n[31:0] ^ 32'h0000_0013;
        e.pc = pc_n;
        e.ins = Ins4;
        e.wen = wen;
        e.rd = rd;
        e.wb = exp_wb;
        #1;
        chk("ready5_on_issue", {63'd0, ready5}, 64'd1);
        sb.push_back(e);
        n_push++;
        pc_n = pc_n + 64'd4;
    endtask

    task automatic do_load(input logic [2:0] op, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp_wb,
                           input int resp_gap);
        issue(1'b1, 1'b0, op, addr, 64'd0, 1'b1, 5'd7, exp_wb);
        cyc();
        valid5 = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("ld_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("ld_req_addr", mem_req_addr, {addr[63:3], 3'b000});
        chk("ld_req_wen", {63'd0, mem_req_wen}, 64'd0);
        cyc();
        mem_req_ready = 1'b0;
        for (int i = 1; i < resp_gap; i++) begin
            #1;
            chk("ld_wait_req_low", {63'd0, mem_req_valid}, 64'd0);
            chk("ld_wait_no_valid6", {63'd0, valid6}, 64'd0);
            cyc();
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        cyc();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("ld_valid6", {63'd0, valid6}, 64'd1);
        cyc();
    endtask

    task automatic do_store(input logic [2:0] op, input logic [63:0] addr,
                            input logic [63:0] sdata, input logic [7:0] exp_mask,
                            input logic [63:0] exp_wdata, input int ready_delay);
        issue(1'b0, 1'b1, op, addr, sdata, 1'b0, 5'd0, addr);
        cyc();
        valid5 = 1'b0;
        store_data = 64'd0;
        alu_res = 64'd0;
        for (int i = 0; i <= ready_delay; i++) begin
            mem_req_ready = (i == ready_delay);
            #1;
            chk("st_req_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("st_req_addr", mem_req_addr, {addr[63:3], 3'b000});
            chk("st_req_wen", {63'd0, mem_req_wen}, 64'd1);
            chk("st_req_wdata", mem_req_wdata, exp_wdata);
            chk("st_req_wmask", {56'd0, mem_req_wmask}, {56'd0, exp_mask});
            cyc();
        end
        mem_req_ready = 1'b0;
        #1;
        chk("st_valid6", {63'd0, valid6}, 64'd1);
        chk("st_req_dropped", {63'd0, mem_req_valid}, 64'd0);
        cyc();
    endtask

    // Scoreboard consumer: compare every handoff to write-back against the queue head.
    always @(negedge clk) begin
        if (reset === 1'b1 && valid6 === 1'b1 && ready6 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", PC6, 64'd0 - 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_pop++;
                chk("sb_pc", PC6, e.pc);
                chk("sb_ins", {32'd0, Ins5}, {32'd0, e.ins});
                chk("sb_wen", {63'd0, reg_w_en4}, {63'd0, e.wen});
                chk("sb_rd", {59'd0, rdest3}, {59'd0, e.rd});
                chk("sb_wb", WB_data1, e.wb);
            end
        end
    end

    initial begin
        reset = 1'b0;
        valid5 = 1'b0;
        PC5 = '0;
        Ins4 = '0;
        reg_w_en3 = 1'b0;
        rdest3_in = '0;
        alu_res = '0;
        store_data = '0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        mem_op = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        ready6 = 1'b1;
        #2;
        chk("rst_valid6", {63'd0, valid6}, 64'd0);
        chk("rst_ready5", {63'd0, ready5}, 64'd1);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_wb", WB_data1, 64'd0);
        chk("rst_pc6", PC6, 64'd0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();

        // Three back-to-back ALU ops, one per cycle.
        issue(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 1'b1, 5'd5, 64'h1234);
        cyc();
        chk("alu_valid6_1", {63'd0, valid6}, 64'd1);
        issue(1'b0, 1'b0, 3'b000, 64'h5678, 64'd0, 1'b1, 5'd6, 64'h5678);
        cyc();
        chk("alu_valid6_2", {63'd0, valid6}, 64'd1);
        issue(1'b0, 1'b0, 3'b000, 64'hFFFF_0000_0000_0001, 64'd0, 1'b0, 5'd31,
              64'hFFFF_0000_0000_0001);
        cyc();
        chk("alu_valid6_3", {63'd0, valid6}, 64'd1);
        valid5 = 1'b0;
        cyc();
        chk("alu_idle_valid6", {63'd0, valid6}, 64'd0);

        do_load(3'b000, 64'h8000_1003, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, 2);
        do_load(3'b100, 64'h8000_1003, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080, 2);
        do_load(3'b001, 64'h8000_1002, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF, 1);
        do_load(3'b110, 64'h8000_1004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 3);
        do_load(3'b011, 64'h8000_2000, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1);

        do_store(3'b001, 64'h8000_2006, 64'h0000_0000_0000_ABCD, 8'hC0,
                 64'hABCD_0000_0000_0000, 3);
        do_store(3'b010, 64'h8000_2006, 64'h0000_0000_1122_3344, 8'hC0,
                 64'h3344_0000_0000_0000, 0);
        do_store(3'b000, 64'h8000_2001, 64'h0000_0000_0000_00A5, 8'h02,
                 64'h0000_0000_0000_A500, 1);

        // Write-back stalls for five cycles; then a new op is captured as the stall clears.
        issue(1'b0, 1'b0, 3'b000, 64'hCAFE, 64'd0, 1'b1, 5'd9, 64'hCAFE);
        cyc();
        valid5 = 1'b1;
        ready6 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_ready5", {63'd0, ready5}, 64'd0);
            chk("hold_valid6", {63'd0, valid6}, 64'd1);
            chk("hold_wb", WB_data1, 64'hCAFE);
            cyc();
        end
        ready6 = 1'b1;
        issue(1'b0, 1'b0, 3'b000, 64'hBEEF, 64'd0, 1'b1, 5'd10, 64'hBEEF);
        cyc();
        chk("hold_next_valid6", {63'd0, valid6}, 64'd1);
        chk("hold_next_wb", WB_data1, 64'hBEEF);
        valid5 = 1'b0;
        cyc();

        // Reset while a load is waiting on its response; the late response is discarded.
        valid5 = 1'b1;
        mem_rd = 1'b1;
        mem_wr = 1'b0;
        mem_op = 3'b011;
        alu_res = 64'h8000_3000;
        PC5 = 64'h8000_0F00;
        cyc();
        valid5 = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rstw_valid6", {63'd0, valid6}, 64'd0);
        chk("rstw_ready5", {63'd0, ready5}, 64'd1);
        chk("rstw_pc6", PC6, 64'd0);
        chk("rstw_addr", mem_req_addr, 64'd0);
        chk("rstw_req_valid", {63'd0, mem_req_valid}, 64'd0);
        cyc();
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h5555_AAAA_5555_AAAA;
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("rstw_late_valid6", {63'd0, valid6}, 64'd0);
        chk("rstw_late_wb", WB_data1, 64'd0);
        cyc();
        chk("rstw_late_valid6_2", {63'd0, valid6}, 64'd0);

        cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("sb_count", 64'(n_pop), 64'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
